// File: rtl/gpt_input_filter_pkg.sv
// Shared types and helpers for the timer input-capture filter.
// icf_decode maps a 4-bit filter code to its sampling divider (log2) and sample count.
package gpt_filter_pkg;

    localparam int PRESC_W = 5;
    localparam int CNT_W   = 3;

    typedef logic [3:0] icf_t;

    typedef struct packed {
        logic [2:0] div_log2;
        logic [3:0] n;
    } filt_cfg_t;

    function automatic filt_cfg_t icf_decode(input icf_t icf);
        filt_cfg_t cfg;
        case (icf)
            4'h0:    cfg = '{3'd0, 4'd1};
            4'h1:    cfg = '{3'd0, 4'd2};
            4'h2:    cfg = '{3'd0, 4'd4};
            4'h3:    cfg = '{3'd0, 4'd8};
            4'h4:    cfg = '{3'd1, 4'd6};
            4'h5:    cfg = '{3'd1, 4'd8};
            4'h6:    cfg = '{3'd2, 4'd6};
            4'h7:    cfg = '{3'd2, 4'd8};
            4'h8:    cfg = '{3'd3, 4'd6};
            4'h9:    cfg = '{3'd3, 4'd8};
            4'hA:    cfg = '{3'd4, 4'd5};
            4'hB:    cfg = '{3'd4, 4'd6};
            4'hC:    cfg = '{3'd4, 4'd8};
            4'hD:    cfg = '{3'd5, 4'd5};
            4'hE:    cfg = '{3'd5, 4'd6};
            default: cfg = '{3'd5, 4'd8};
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/gpt_input_filter_if.sv
// Pin-side bundle between the timer inputs and the capture filter.
// The master drives enable, filter codes and raw inputs; the slave returns filtered levels and strobes.
interface gpt_input_filter_if #(parameter int CHANNELS = 4);
    import gpt_filter_pkg::*;

    logic                  en_i;
    icf_t [CHANNELS-1:0]   icf_i;
    logic [CHANNELS-1:0]   a_i;
    logic [CHANNELS-1:0]   af_o;
    logic [CHANNELS-1:0]   rise_o;
    logic [CHANNELS-1:0]   fall_o;

    modport master (output en_i, icf_i, a_i, input af_o, rise_o, fall_o);
    modport slave  (input en_i, icf_i, a_i, output af_o, rise_o, fall_o);

endinterface

// File: rtl/gpt_input_filter_ch.sv
// One filter channel: synchroniser, code-change detect, consecutive-sample counter
// and registered level/edge outputs, sampling on ticks derived from the shared prescaler.
module gpt_input_filter_ch
    import gpt_filter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               aresetn_i,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  icf_t               icf_i,
    input  logic               a_i,
    output logic               af_o,
    output logic               rise_o,
    output logic               fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    icf_t                   icf_q;
    logic [CNT_W-1:0]       cnt_q;
    filt_cfg_t              cfg;
    logic [PRESC_W-1:0]     tick_mask;
    logic                   s;
    logic                   tick;
    logic                   last_sample;

    assign cfg         = icf_decode(icf_i);
    // A divider of 2^L ticks when the low L prescaler bits are all ones; L=0 ticks every cycle.
    assign tick_mask   = PRESC_W'((32'd1 << cfg.div_log2) - 32'd1);
    assign tick        = &(presc_i | ~tick_mask);
    assign s           = sync_q[SYNC_STAGES-1];
    assign last_sample = ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1)) == cfg.n;

    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= a_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // The previous code tracks the input during reset so a code held through reset is not seen as a change.
    always_ff @(posedge clk_i) begin
        icf_q  <= icf_i;
        rise_o <= 1'b0;
        fall_o <= 1'b0;
        if (!aresetn_i) begin
            cnt_q <= '0;
            af_o  <= 1'b0;
        end else if (!en_i || (icf_i != icf_q)) begin
            cnt_q <= '0;
        end else if (tick) begin
            if (s == af_o) begin
                cnt_q <= '0;
            end else if (last_sample) begin
                af_o   <= s;
                cnt_q  <= '0;
                rise_o <= s;
                fall_o <= ~s;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpt_input_filter.sv
// Multi-channel timer input-capture filter: owns the shared sampling prescaler
// and replicates one independent filter channel per input pin.
module gpt_input_filter
    import gpt_filter_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 aresetn_i,
    gpt_input_filter_if.slave    bus
);

    logic [PRESC_W-1:0]  presc_q;
    logic [CHANNELS-1:0] af;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    always_ff @(posedge clk_i) begin
        if (!aresetn_i || !bus.en_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        gpt_input_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk_i     (clk_i),
            .aresetn_i (aresetn_i),
            .en_i      (bus.en_i),
            .presc_i   (presc_q),
            .icf_i     (bus.icf_i[i]),
            .a_i       (bus.a_i[i]),
            .af_o      (af[i]),
            .rise_o    (rise[i]),
            .fall_o    (fall[i])
        );
    end

    assign bus.af_o   = af;
    assign bus.rise_o = rise;
    assign bus.fall_o = fall;

endmodule

// File: tb/tb_gpt_input_filter.sv
// Directed scenarios followed by randomized traffic, every cycle compared against
// a reference model built from the filter's sampling rules with plain integer arithmetic.
module tb_gpt_input_filter;

    localparam int CH = 4;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic aresetn;
    int   checks = 0;
    int   failures = 0;

    gpt_input_filter_if #(.CHANNELS(CH)) bus ();

    gpt_input_filter #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_i     (clk),
        .aresetn_i (aresetn),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int div_tab [16] = '{1, 1, 1, 1, 2, 2, 4, 4, 8, 8, 16, 16, 16, 32, 32, 32};
    int n_tab   [16] = '{1, 2, 4, 8, 6, 8, 6, 8, 6, 8, 5, 6, 8, 5, 6, 8};

    logic [CH-1:0] hist [SS];
    int            cycle_m;
    int            run_m [CH];
    logic [CH-1:0] af_m, rise_m, fall_m;
    logic [3:0]    icf_prev [CH];

    // Reference: s is the raw input seen SS edges ago; sampling happens when the
    // enabled-cycle count modulo the divider reaches divider-1.
    task automatic model_update(input logic rst_n, input logic en,
                                input logic [CH-1:0][3:0] icf, input logic [CH-1:0] a);
        if (!rst_n) begin
            for (int k = 0; k < SS; k++) hist[k] = '0;
            cycle_m = 0;
            af_m = '0; rise_m = '0; fall_m = '0;
            for (int c = 0; c < CH; c++) begin
                run_m[c] = 0;
                icf_prev[c] = icf[c];
            end
        end else begin
            rise_m = '0; fall_m = '0;
            for (int c = 0; c < CH; c++) begin
                int d, n;
                logic s;
                s = hist[SS-1][c];
                d = div_tab[icf[c]];
                n = n_tab[icf[c]];
                if (!en || icf[c] != icf_prev[c]) begin
                    run_m[c] = 0;
                end else if ((cycle_m % d) == d - 1) begin
                    if (s == af_m[c]) begin
                        run_m[c] = 0;
                    end else if (run_m[c] + 1 == n) begin
                        af_m[c] = s;
                        run_m[c] = 0;
                        if (s) rise_m[c] = 1'b1;
                        else   fall_m[c] = 1'b1;
                    end else begin
                        run_m[c] = run_m[c] + 1;
                    end
                end
                icf_prev[c] = icf[c];
            end
            for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = a;
            cycle_m = en ? (cycle_m + 1) % 32 : 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("af",   32'(bus.af_o),   32'(af_m));
        check("rise", 32'(bus.rise_o), 32'(rise_m));
        check("fall", 32'(bus.fall_o), 32'(fall_m));
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            logic rst_c, en_c;
            logic [CH-1:0][3:0] icf_c;
            logic [CH-1:0] a_c;
            rst_c = aresetn; en_c = bus.en_i; icf_c = bus.icf_i; a_c = bus.a_i;
            @(posedge clk);
            model_update(rst_c, en_c, icf_c, a_c);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        int first, rises;
        int first_ch [CH];

        // Reset with all inputs high, then the fastest code passes after SS+1 edges.
        aresetn = 1'b0; bus.en_i = 1'b1; bus.a_i = '1; bus.icf_i = '0;
        applyStimulus(3);
        check("reset_af", 32'(bus.af_o), 32'h0);
        aresetn = 1'b1;
        first = -1;
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1);
            if (first < 0 && bus.af_o == '1) begin
                first = k;
                check("reset_rise", 32'(bus.rise_o), 32'hF);
            end
        end
        check("reset_latency", 32'(first), 32'(SS + 1));

        // Seven-sample pulse rejected with N=8, eight-sample pulse accepted.
        bus.a_i = '0; bus.icf_i = {CH{4'h3}};
        applyStimulus(15);
        bus.a_i = '1; applyStimulus(7);
        bus.a_i = '0;
        rises = 0;
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1);
            rises += $countones(bus.rise_o);
        end
        check("glitch7_rises", 32'(rises), 32'h0);
        check("glitch7_af", 32'(bus.af_o), 32'h0);
        bus.a_i = '1; first = -1; rises = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1);
            rises += $countones(bus.rise_o);
            if (first < 0 && bus.af_o == '1) first = k;
        end
        check("n8_latency", 32'(first), 32'(SS + 8));
        check("n8_rises", 32'(rises), 32'(CH));

        // Divided rate (32,8): 256 stable clocks pass, a 200-clock pulse is rejected.
        bus.icf_i = {CH{4'hF}}; bus.a_i = '0;
        applyStimulus(300);
        bus.a_i = '1; first = -1;
        for (int k = 1; k <= 400 && first < 0; k++) begin
            applyStimulus(1);
            if (bus.af_o == '1) first = k;
        end
        check("div_pass", 32'(first > 0 && first <= 256 + SS), 32'h1);
        bus.a_i = '0; applyStimulus(300);
        bus.a_i = '1; rises = 0;
        for (int k = 0; k < 200; k++) begin
            applyStimulus(1);
            rises += $countones(bus.rise_o);
        end
        bus.a_i = '0;
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1);
            rises += $countones(bus.rise_o);
        end
        check("div_reject", 32'(rises), 32'h0);

        // Restart: 3 high, 1 low, 4 high with N=4 rises only at the end of the second run.
        bus.icf_i = {CH{4'h2}}; bus.a_i = '0;
        applyStimulus(20);
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            bus.a_i = (k <= 3 || (k >= 5 && k <= 8)) ? '1 : '0;
            applyStimulus(1);
            if (first < 0 && bus.af_o == '1) first = k;
        end
        check("restart_latency", 32'(first), 32'h0A);

        // Code switch 0011->0001 after five counted samples: two more samples needed.
        bus.icf_i = {CH{4'h3}}; bus.a_i = '0;
        applyStimulus(20);
        first = -1; bus.a_i = '1;
        for (int k = 1; k <= 20; k++) begin
            if (k >= 8) bus.icf_i = {CH{4'h1}};
            applyStimulus(1);
            if (first < 0 && bus.af_o == '1) first = k;
        end
        check("icf_switch_latency", 32'(first), 32'h0A);

        // Enable dropped mid-count: counting restarts from zero after re-enable.
        bus.icf_i = {CH{4'h3}}; bus.a_i = '0;
        applyStimulus(20);
        first = -1; bus.a_i = '1;
        for (int k = 1; k <= 30; k++) begin
            bus.en_i = !(k >= 6 && k <= 9);
            applyStimulus(1);
            if (first < 0 && bus.af_o == '1) first = k;
        end
        check("en_restart_latency", 32'(first), 32'h11);

        // Independent channels, each with its own code, toggled together.
        bus.icf_i = {4'h9, 4'h5, 4'h1, 4'h0}; bus.a_i = '0;
        applyStimulus(100);
        bus.a_i = '1;
        for (int c = 0; c < CH; c++) first_ch[c] = -1;
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(1);
            for (int c = 0; c < CH; c++)
                if (first_ch[c] < 0 && bus.af_o[c]) first_ch[c] = k;
        end
        check("ch0_latency", 32'(first_ch[0]), 32'(SS + 1));
        check("ch1_latency", 32'(first_ch[1]), 32'(SS + 2));
        check("ch2_bound", 32'(first_ch[2] > SS + 7 && first_ch[2] <= 2 * 8 + SS), 32'h1);
        check("ch3_bound", 32'(first_ch[3] > 7 * 8 && first_ch[3] <= 8 * 8 + SS), 32'h1);

        // Randomized traffic: bursty inputs, occasional code, enable and reset changes.
        for (int k = 0; k < 4000; k++) begin
            logic [CH-1:0] flip;
            for (int c = 0; c < CH; c++) flip[c] = ($urandom_range(0, 11) == 0);
            bus.a_i = bus.a_i ^ flip;
            if ($urandom_range(0, 149) == 0)
                bus.icf_i[$urandom_range(0, CH - 1)] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 99) == 0) bus.en_i = ~bus.en_i;
            else if (!bus.en_i && $urandom_range(0, 7) == 0) bus.en_i = 1'b1;
            aresetn = ($urandom_range(0, 999) != 0);
            applyStimulus(1);
        end
        aresetn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpt_input_filter.md
# gpt_input_filter

Multi-channel input-capture filter for the general-purpose timer. Each channel synchronises an asynchronous timer input and accepts a level change only after N consecutive equal samples taken at a divided sampling rate. It also produces one-cycle rising and falling edge strobes. The block sits between the timer input pins and the capture/trigger logic, and replaces the single-channel filter with a per-channel ICF code decoded to a (divider, N) pair.

## Interface
- CHANNELS, 4: number of independent input channels (1..16).
- SYNC_STAGES, 2: synchroniser flops per channel (1..3).
- clk_i  in  1  timer kernel clock; all logic on rising edge.
- aresetn_i  in  1  synchronous, active-low reset.
- en_i  in  1  filter enable; low holds prescaler and all counters cleared, outputs frozen.
- icf_i  in  CHANNELS×4  per-channel filter code (icf_t, packed [CHANNELS-1:0][3:0]).
- a_i  in  CHANNELS  raw asynchronous inputs.
- af_o  out  CHANNELS  filtered levels.
- rise_o  out  CHANNELS  one-cycle strobe, af_o went 0→1.
- fall_o  out  CHANNELS  one-cycle strobe, af_o went 1→0.

## Operation
- ICF decode gives (D = sampling divider, N = samples): 0000 (1,1); 0001 (1,2); 0010 (1,4); 0011 (1,8); 0100 (2,6); 0101 (2,8); 0110 (4,6); 0111 (4,8); 1000 (8,6); 1001 (8,8); 1010 (16,5); 1011 (16,6); 1100 (16,8); 1101 (32,5); 1110 (32,6); 1111 (32,8).
- Shared 5-bit prescaler: free-running while en_i=1, cleared while en_i=0. Sample tick for divider D=2^L is asserted when prescaler[L-1:0] are all ones; L=0 ticks every cycle.
- Per channel: s = last synchroniser stage; 3-bit counter cnt.
  - On a tick with s == af_o: cnt←0.
  - On a tick with s != af_o and cnt+1 == N: af_o←s, cnt←0, strobe asserted.
  - Otherwise on a tick with s != af_o: cnt←cnt+1.
  - No tick: hold.
- Change of icf_i on a channel (registered previous code differs): cnt←0 that cycle; af_o holds; no tick is processed for that channel that cycle.
- en_i low: cnt←0 and prescaler←0; synchronisers keep running; af_o holds; strobes 0.
- Channels are fully independent apart from the shared prescaler.

## Timing
- Reset (aresetn_i=0 at an edge): synchroniser flops, cnt, prescaler, af_o, rise_o and fall_o all become 0. Reset mid-count discards the count.
- rise_o/fall_o are registered and asserted in the same cycle af_o changes, for exactly one cycle.
- Latency for D=1, input stable and set up before edge 1: af_o changes after edge SYNC_STAGES+N. For ICF 0000 this is SYNC_STAGES+1; for 0011 it is SYNC_STAGES+8.
- For divided rates, a level stable at s for N·D clocks always passes. A level stable for fewer than (N−1)·D+1 clocks is always rejected.
- Glitch back to the af_o level on any tick restarts the count from 0.
- Max cnt value is 7 (N≤8); no wrap is reachable.

## Structure
- Package gpt_filter_pkg holds:
  - icf_t (logic [3:0]);
  - filt_cfg_t struct {div_log2 [2:0], n [3:0]};
  - function icf_decode(icf_t) returning filt_cfg_t;
  - localparams PRESC_W=5 and CNT_W=3.
- Sub-module gpt_input_filter_ch contains one channel: synchroniser, ICF-change detect, counter, af/rise/fall registers, tick-select from prescaler.
- The top level instantiates CHANNELS copies and owns the prescaler.

## Test plan
- Reset/idle: aresetn_i=0 for 3 cycles with a_i all ones, then release with ICF=0000 → af_o=0 during reset; af_o=1 and rise_o pulse after edge SYNC_STAGES+1 post-release.
- Glitch rejection: ICF=0011, D=1, a_i high for 7 cycles then low → af_o stays 0, no strobes. Held 8 cycles → af_o=1 at edge SYNC_STAGES+8, rise_o single pulse.
- Divided rate: ICF=1111 (32,8), a_i held high 256 cycles → af_o=1 no later than 256+SYNC_STAGES cycles. A 200-cycle pulse (<7·32+1) → rejected.
- Restart: ICF=0010, high 3 cycles, low 1, high 4 → af_o rises only after the second run of 4 samples.
- Mid-operation changes: ICF switched 0011→0001 after 5 counted samples → cnt cleared; af_o rises 2 samples after the switch. en_i dropped mid-count → no change; count restarts from 0 after re-enable.
- Channel independence: CHANNELS=4, each with a different ICF, simultaneous toggles on all a_i → each af_o follows its own latency, with no cross-channel effect.
